// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants, state encoding and the IF/ID bundle layout
// consumed by the decode stage.
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  TEXT_BASE  = 32'h0040_0000;
    localparam logic [ADDR_W-1:0]  TEXT_LIMIT = 32'h0040_4000;
    localparam logic [INSTR_W-1:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
    } if_id_t;

endpackage

// File: rtl/pc_range_check.sv
// Combinational legality check for a word fetch/access address:
// word aligned and within [lo, hi] inclusive.
module pc_range_check
    import fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic              legal
);

    assign legal = (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID register; a bad next-PC latches a sticky fault.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = TEXT_BASE,
    parameter logic [ADDR_W-1:0]  LIMIT_ADDR = TEXT_LIMIT,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    if_id_t            if_id_q, if_id_d;
    logic              fault_q, fault_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] next_addr;
    logic              next_legal;

    assign pc_plus4  = pc_q + 32'd4;
    assign next_addr = redirect ? redirect_target : pc_plus4;

    pc_range_check u_range (
        .addr  (next_addr),
        .lo    (BASE_ADDR),
        .hi    (LIMIT_ADDR),
        .legal (next_legal)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_d       = if_id_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    if_id_d.valid = 1'b0;
                    if_id_d.instr = NOP_INSTR;
                    if (next_legal) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (!stall) begin
                    // The current word is still delivered even if the advance faults.
                    if_id_d.valid = 1'b1;
                    if_id_d.instr = imem_data;
                    if_id_d.pc    = pc_q;
                    if_id_d.pc4   = pc_plus4;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (next_legal) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            FAULT: begin
                if_id_d.valid = 1'b0;
                if_id_d.instr = NOP_INSTR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= BASE_ADDR;
            if_id_q.valid <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
            if_id_q.pc    <= '0;
            if_id_q.pc4   <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Memory address comes straight from the PC register, never from stall/redirect.
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_q.valid;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a reference model pushes expected
// post-edge outputs per cycle; each scenario pops and compares them.
module tb_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] LIMIT = 32'h0040_4000;

    typedef logic [161:0] obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fault;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    obs_t sb[$];
    obs_t exp_v;
    obs_t obs;

    logic        m_st, m_valid, m_fault;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic ok_addr(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a <= LIMIT);
    endfunction

    assign imem_data = mem(imem_addr);
    assign obs = {if_id_valid, if_id_instr, if_id_pc, if_id_pc4, fault, fetch_count, imem_addr};

    // Drive one cycle, advance the model, push the expected outputs, wait past the edge.
    task automatic cyc(input logic r_in, input logic s_in, input logic d_in, input logic [31:0] t_in);
        reset = r_in; stall = s_in; redirect = d_in; redirect_target = t_in;
        if (r_in) begin
            m_pc = BASE; m_st = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;
        end else if (!m_st) begin
            if (d_in) begin
                m_valid = 1'b0; m_instr = 32'h0;
                if (ok_addr(t_in)) m_pc = t_in;
                else begin m_st = 1'b1; m_fault = 1'b1; end
            end else if (!s_in) begin
                m_valid = 1'b1; m_instr = mem(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
                if (ok_addr(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
                else begin m_st = 1'b1; m_fault = 1'b1; end
            end
        end else begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
        sb.push_back({m_valid, m_instr, m_ipc, m_ipc4, m_fault, m_cnt, m_pc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_sb got=%h want=%h", obs, exp_v); end
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || fault !== 1'b0
            || fetch_count !== 32'h0 || imem_addr !== BASE) begin
            n_errors++; $display("FAIL reset_vals got v=%b i=%h pc=%h f=%b c=%0d a=%h want 0/0/0/0/0/%h",
                if_id_valid, if_id_instr, if_id_pc, fault, fetch_count, imem_addr, BASE);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL seq_%0d got=%h want=%h", i, obs, exp_v); end
            n_checks++;
            if (if_id_pc !== BASE + 32'(4 * i) || if_id_instr !== mem(BASE + 32'(4 * i))) begin
                n_errors++; $display("FAIL seq_word_%0d got pc=%h instr=%h want pc=%h", i, if_id_pc, if_id_instr, BASE + 32'(4 * i));
            end
        end
        n_checks++;
        if (fetch_count !== 32'd4 || if_id_pc4 !== 32'h0040_0010) begin
            n_errors++; $display("FAIL seq_count got c=%0d pc4=%h want 4/00400010", fetch_count, if_id_pc4);
        end
    endtask

    task automatic test_stall();
        cyc(1, 0, 0, 0); void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            cyc(0, (i >= 2 && i < 5), 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL stall_%0d got=%h want=%h", i, obs, exp_v); end
            if (i == 4) begin
                n_checks++;
                if (imem_addr !== 32'h0040_0008 || if_id_instr !== mem(32'h0040_0004) || fetch_count !== 32'd2) begin
                    n_errors++; $display("FAIL stall_hold got a=%h i=%h c=%0d want 00400008/%h/2",
                        imem_addr, if_id_instr, fetch_count, mem(32'h0040_0004));
                end
            end
        end
        n_checks++;
        if (if_id_instr !== mem(32'h0040_0008) || fetch_count !== 32'd3) begin
            n_errors++; $display("FAIL stall_release got i=%h c=%0d want %h/3", if_id_instr, fetch_count, mem(32'h0040_0008));
        end
    endtask

    task automatic test_redirect();
        cyc(0, 1, 1, 32'h0040_0100);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL redir_sb got=%h want=%h", obs, exp_v); end
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_count !== 32'd3) begin
            n_errors++; $display("FAIL redir_flush got v=%b i=%h c=%0d want 0/0/3", if_id_valid, if_id_instr, fetch_count);
        end
        cyc(0, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL redir_next_sb got=%h want=%h", obs, exp_v); end
        n_checks++;
        if (if_id_pc !== 32'h0040_0100 || if_id_valid !== 1'b1) begin
            n_errors++; $display("FAIL redir_target got pc=%h v=%b want 00400100/1", if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_fault_misaligned();
        logic [31:0] held;
        held = imem_addr;
        cyc(0, 0, 1, 32'h0040_0102);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL mis_sb got=%h want=%h", obs, exp_v); end
        n_checks++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== held) begin
            n_errors++; $display("FAIL mis_fault got f=%b v=%b a=%h want 1/0/%h", fault, if_id_valid, imem_addr, held);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, i[0], i[1], 32'h0040_0200);
            exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL mis_hold_%0d got=%h want=%h", i, obs, exp_v); end
        end
        n_checks++;
        if (imem_addr !== held || fault !== 1'b1) begin
            n_errors++; $display("FAIL mis_sticky got a=%h f=%b want %h/1", imem_addr, fault, held);
        end
        cyc(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (imem_addr !== BASE || fault !== 1'b0 || obs !== exp_v) begin
            n_errors++; $display("FAIL mis_reset got a=%h f=%b want %h/0", imem_addr, fault, BASE);
        end
        cyc(0, 0, 1, 32'h003F_FFFC);
        exp_v = sb.pop_front(); n_checks++;
        if (fault !== 1'b1 || imem_addr !== BASE || obs !== exp_v) begin
            n_errors++; $display("FAIL below_base got f=%b a=%h want 1/%h", fault, imem_addr, BASE);
        end
        cyc(1, 0, 0, 0); void'(sb.pop_front());
    endtask

    task automatic test_limit();
        cyc(0, 0, 1, 32'h0040_3FF8);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL lim_redir got=%h want=%h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL lim_run_%0d got=%h want=%h", i, obs, exp_v); end
        end
        n_checks++;
        if (if_id_pc !== LIMIT || if_id_valid !== 1'b1 || fault !== 1'b1 || if_id_instr !== mem(LIMIT)
            || imem_addr !== LIMIT) begin
            n_errors++; $display("FAIL lim_last got pc=%h v=%b f=%b a=%h want %h/1/1/%h",
                if_id_pc, if_id_valid, fault, imem_addr, LIMIT, LIMIT);
        end
        cyc(0, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (if_id_valid !== 1'b0 || obs !== exp_v) begin
            n_errors++; $display("FAIL lim_after got v=%b obs=%h want 0 %h", if_id_valid, obs, exp_v);
        end
    endtask

    task automatic test_reset_in_stall();
        cyc(1, 0, 0, 0); void'(sb.pop_front());
        cyc(0, 0, 0, 0); void'(sb.pop_front());
        cyc(0, 0, 0, 0); void'(sb.pop_front());
        cyc(0, 1, 0, 0); void'(sb.pop_front());
        cyc(1, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || if_id_valid !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== BASE) begin
            n_errors++; $display("FAIL rst_stall got=%h want=%h", obs, exp_v);
        end
        cyc(0, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (obs !== exp_v || if_id_pc !== BASE || fetch_count !== 32'd1) begin
            n_errors++; $display("FAIL rst_resume got pc=%h c=%0d want %h/1", if_id_pc, fetch_count, BASE);
        end
    endtask

    task automatic test_back_to_back();
        logic s, d;
        logic [31:0] t;
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            t = BASE + {$urandom_range(0, 255), 2'b00};
            cyc(0, s, d, t);
            exp_v = sb.pop_front(); n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL b2b_%0d got=%h want=%h", i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_misaligned();
        test_limit();
        test_reset_in_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
